eq_coef_regbank: RTL and testbench
==================================

# eq_coef_regbank

Register bank that sits directly downstream of the I2C slave in the digital audio equalizer. Consumes the slave's byte-write strobe (`reg_addr`, `reg_data`, `reg_we`), holds per-band gain settings in shadow registers, and transfers them to the active gains that drive the filter bank only at audio sample boundaries after an explicit commit. Active gains ramp toward their targets one step per sample to avoid zipper noise. Also provides a registered read port that feeds the slave's `data_in` for master reads.

## Interface
Parameters:
- `NUM_BANDS`, 8, number of equalizer bands (1..16)
- `BAND_BASE`, 8'h00, address of band 0 gain; band i at `BAND_BASE + i`
- `CTRL_ADDR`, 8'h20, control register address
- `STATUS_ADDR`, 8'h21, read-only status address
- `STEP_ADDR`, 8'h22, ramp step register address
- `RESET_STEP`, 8'd1, reset value of ramp step

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1 system clock
- `rst_n` in 1 synchronous active-low reset
- `reg_addr` in 8 write address from I2C slave
- `reg_data` in 8 write data from I2C slave
- `reg_we` in 1 single-cycle write strobe
- `rd_addr` in 8 read address
- `rd_data` out 8 registered read data (to slave `data_in`)
- `sample_tick` in 1 one-cycle pulse per audio sample
- `gain_flat` out NUM_BANDS*8 active gains, band i at [8i+7:8i], signed two's complement
- `bypass` out 1 equalizer bypass (CTRL bit1)
- `commit_pending` out 1 commit requested, not yet applied
- `ramping` out 1 any active gain ≠ its target

## Operation
- Storage per band: `shadow[i]`, `target[i]`, `active[i]`, each 8-bit signed.
- Write (`reg_we`=1) decode:
  - band address: `shadow[i] <= reg_data`.
  - `CTRL_ADDR`: bit0=1 sets `commit_pending`; bit1 -> `bypass`; other bits ignored, bit0 not stored.
  - `STEP_ADDR`: `step <= reg_data` (unsigned).
  - `STATUS_ADDR` and unmapped: ignored.
- Commit: on `sample_tick` with `commit_pending`=1: `target[i] <= shadow[i]` for all i (values as registered before the edge), `commit_pending <= 0`. A CTRL commit write in the same cycle as that tick keeps `commit_pending` at 1 (new request wins).
- Shadow write coincident with committing tick: shadow takes new value, target gets old value.
- Ramp (per `sample_tick`, every band): diff = target − active in 9-bit signed; if |diff| ≤ step or step=0, active <= target; else active moves toward target by step. No overflow/wrap: computation in 9 bits, result always within [-128,127].
- Ramp uses targets from before the edge; newly committed targets start ramping on the next tick.
- `ramping` = OR over bands of (active ≠ target), combinational from registers.
- Read mux: band -> shadow[i]; CTRL -> {6'b0, bypass, 1'b0}; STATUS -> {6'b0, ramping, commit_pending}; STEP -> step; unmapped -> 8'h00.
- Reset: all shadow/target/active = 0, step = `RESET_STEP`, bypass=0, commit_pending=0, rd_data=0. Reset mid-ramp or with commit pending abandons it.

## Timing
- Write -> shadow/CTRL/STEP visible: next edge after `reg_we`.
- Read latency: `rd_data` valid 1 cycle after `rd_addr` presented; updates every cycle.
- Commit -> target: at first `sample_tick` edge after `commit_pending` set (≥1 cycle after write).
- target -> active: ceil(|diff|/step) further ticks (1 if step=0).
- `sample_tick` held high multiple cycles is treated as one tick per cycle high (no edge detect).

## Configuration
- `EQ_GAIN_RAMP_EN` defined: ramp as described.
- Not defined: `target` register omitted; on committing tick `active[i] <= shadow[i]` directly; `ramping` tied 0; `step` register still readable/writable but unused.

## Test plan
- Reset -> gain_flat=0, rd_data=0, STEP read=8'h01, STATUS=8'h00.
- Write band2=8'h10, no commit, 5 ticks -> gain_flat band2 stays 0; read band2 returns 8'h10.
- Step=4, band0=8'h0A, CTRL=8'h01, ticks -> commit_pending clears at tick1; active band0 = 4, 8, 10(0x0A) on ticks 2,3,4; ramping falls after tick4.
- band1=8'h80 (−128) from 8'h7F active, step=8'hFF -> single-tick jump to 8'h80, no wrap.
- CTRL commit write same cycle as tick while pending -> commit applied, commit_pending remains 1, second commit on next tick.
- rst_n low mid-ramp for 1 cycle -> all gains 0, step=1, commit_pending=0 next cycle.

Source files
------------

// File: rtl/eq_coef_regbank.sv
// ---------------------------------------------------------------------------
// eq_coef_regbank
//
// Per-band gain register bank for the audio equalizer. Byte writes arriving
// from the I2C slave land in shadow registers. A commit request (CTRL bit0)
// transfers every shadow value at the next audio sample tick, so all bands
// change together on a sample boundary.
//
// Optional feature macro: EQ_GAIN_RAMP_EN
//   Defined     - committed values go to per-band targets, and the active
//                 gains ramp toward them by 'step' on every sample tick.
//   Not defined - committed values go straight to the active gains, and
//                 'ramping' is tied low. 'step' stays readable and writable.
//
// Ports
//   clk_i            system clock
//   rst_ni           synchronous active-low reset
//   reg_addr_i       write address from the I2C slave
//   reg_data_i       write data from the I2C slave
//   reg_we_i         single-cycle write strobe
//   rd_addr_i        read address
//   rd_data_o        registered read data (one cycle of latency)
//   sample_tick_i    one-cycle pulse per audio sample
//   gain_flat_o      active gains, band i at [8i+7:8i], signed
//   bypass_o         equalizer bypass (CTRL bit1)
//   commit_pending_o commit requested but not yet applied
//   ramping_o        some active gain has not yet reached its target
// ---------------------------------------------------------------------------
module eq_coef_regbank #(
  parameter int         NUM_BANDS   = 8,
  parameter logic [7:0] BAND_BASE   = 8'h00,
  parameter logic [7:0] CTRL_ADDR   = 8'h20,
  parameter logic [7:0] STATUS_ADDR = 8'h21,
  parameter logic [7:0] STEP_ADDR   = 8'h22,
  parameter logic [7:0] RESET_STEP  = 8'd1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [7:0]             reg_addr_i,
  input  logic [7:0]             reg_data_i,
  input  logic                   reg_we_i,
  input  logic [7:0]             rd_addr_i,
  output logic [7:0]             rd_data_o,
  input  logic                   sample_tick_i,
  output logic [NUM_BANDS*8-1:0] gain_flat_o,
  output logic                   bypass_o,
  output logic                   commit_pending_o,
  output logic                   ramping_o
);

  localparam logic [8:0] NumBands9 = 9'(NUM_BANDS);

  logic [7:0] shadow_q [NUM_BANDS];
  logic [7:0] shadow_d [NUM_BANDS];
  logic [7:0] active_q [NUM_BANDS];
  logic [7:0] active_d [NUM_BANDS];
`ifdef EQ_GAIN_RAMP_EN
  logic [7:0] target_q [NUM_BANDS];
  logic [7:0] target_d [NUM_BANDS];
`endif
  logic [7:0] step_q, step_d;
  logic       bypass_q, bypass_d;
  logic       commit_pending_q, commit_pending_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       ramping;

  logic [7:0] wrOff, rdOff;
  logic       wrBandHit, rdBandHit, commitTick;

  // Band addresses form a window of NUM_BANDS bytes starting at BAND_BASE.
  // The offset is widened by one bit so a window near 8'hFF cannot wrap.
  assign wrOff      = reg_addr_i - BAND_BASE;
  assign rdOff      = rd_addr_i - BAND_BASE;
  assign wrBandHit  = (reg_addr_i >= BAND_BASE) && ({1'b0, wrOff} < NumBands9);
  assign rdBandHit  = (rd_addr_i >= BAND_BASE) && ({1'b0, rdOff} < NumBands9);
  assign commitTick = sample_tick_i && commit_pending_q;

`ifdef EQ_GAIN_RAMP_EN
  // Move one step toward the target. The difference is taken in 9 bits, so
  // a full-scale swing such as 127 -> -128 cannot overflow. When the
  // remaining distance fits in one step the value lands on the target.
  // Otherwise the 8-bit add or subtract stays in range by construction.
  function automatic logic [7:0] rampStep(input logic [7:0] act,
                                          input logic [7:0] tgt,
                                          input logic [7:0] stp);
    logic signed [8:0] diff;
    logic [8:0]        mag;
    diff = $signed({tgt[7], tgt}) - $signed({act[7], act});
    mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    if (stp == 8'd0 || mag <= {1'b0, stp}) return tgt;
    else if (!diff[8])                     return act + stp;
    else                                   return act - stp;
  endfunction
`endif

  // Shadow writes, control/step decode and commit handshake. A commit
  // write that coincides with the committing tick re-arms the request.
  always_comb begin
    for (int i = 0; i < NUM_BANDS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (reg_we_i && wrBandHit && wrOff == 8'(i)) shadow_d[i] = reg_data_i;
    end
    commit_pending_d = commit_pending_q;
    bypass_d         = bypass_q;
    step_d           = step_q;
    if (commitTick) commit_pending_d = 1'b0;
    if (reg_we_i && !wrBandHit) begin
      if (reg_addr_i == CTRL_ADDR) begin
        if (reg_data_i[0]) commit_pending_d = 1'b1;
        bypass_d = reg_data_i[1];
      end else if (reg_addr_i == STEP_ADDR) begin
        step_d = reg_data_i;
      end
    end
  end

  // Gain datapath. With ramping enabled the ramp uses the targets from
  // before this edge, so a newly committed target starts moving on the
  // following tick.
  always_comb begin
    ramping = 1'b0;
    for (int i = 0; i < NUM_BANDS; i++) begin
`ifdef EQ_GAIN_RAMP_EN
      target_d[i] = commitTick ? shadow_q[i] : target_q[i];
      active_d[i] = sample_tick_i ? rampStep(active_q[i], target_q[i], step_q)
                                  : active_q[i];
      if (active_q[i] != target_q[i]) ramping = 1'b1;
`else
      active_d[i] = commitTick ? shadow_q[i] : active_q[i];
`endif
    end
  end

  // Read mux, registered every cycle. Band reads return the shadow value.
  always_comb begin
    rd_data_d = 8'h00;
    if (rdBandHit) begin
      for (int i = 0; i < NUM_BANDS; i++)
        if (rdOff == 8'(i)) rd_data_d = shadow_q[i];
    end else if (rd_addr_i == CTRL_ADDR) begin
      rd_data_d = {6'b0, bypass_q, 1'b0};
    end else if (rd_addr_i == STATUS_ADDR) begin
      rd_data_d = {6'b0, ramping, commit_pending_q};
    end else if (rd_addr_i == STEP_ADDR) begin
      rd_data_d = step_q;
    end
  end

  // State registers. Reset abandons any ramp or pending commit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        shadow_q[i] <= 8'h00;
        active_q[i] <= 8'h00;
`ifdef EQ_GAIN_RAMP_EN
        target_q[i] <= 8'h00;
`endif
      end
      step_q           <= RESET_STEP;
      bypass_q         <= 1'b0;
      commit_pending_q <= 1'b0;
      rd_data_q        <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
`ifdef EQ_GAIN_RAMP_EN
        target_q[i] <= target_d[i];
`endif
      end
      step_q           <= step_d;
      bypass_q         <= bypass_d;
      commit_pending_q <= commit_pending_d;
      rd_data_q        <= rd_data_d;
    end
  end

  for (genvar g = 0; g < NUM_BANDS; g++) begin : gGain
    assign gain_flat_o[8*g +: 8] = active_q[g];
  end

  assign rd_data_o        = rd_data_q;
  assign bypass_o         = bypass_q;
  assign commit_pending_o = commit_pending_q;
  assign ramping_o        = ramping;

endmodule

// File: tb/tb_eq_coef_regbank.sv
// ---------------------------------------------------------------------------
// tb_eq_coef_regbank
//
// Bench for eq_coef_regbank. It keeps a behavioural model of the register
// bank built from integer arithmetic. Each cycle the bench drives inputs,
// advances the model, waits for the falling edge and compares every DUT
// output against the model. Directed sequences with literal expectations
// pin the model, and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_eq_coef_regbank;

  localparam int         NB       = 8;
  localparam logic [7:0] BandBase = 8'h00;
  localparam logic [7:0] CtrlA    = 8'h20;
  localparam logic [7:0] StatA    = 8'h21;
  localparam logic [7:0] StepA    = 8'h22;
`ifdef EQ_GAIN_RAMP_EN
  localparam bit RampEn = 1'b1;
`else
  localparam bit RampEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstN;
  logic [7:0]    regAddr, regData, rdAddr, rdData;
  logic          regWe, sampleTick;
  logic [NB*8-1:0] gainFlat;
  logic          bypass, commitPending, ramping;

  int checks = 0;
  int failures = 0;

  logic [7:0] mShadow [NB];
  logic [7:0] mTarget [NB];
  logic [7:0] mActive [NB];
  logic [7:0] mStep, mRd;
  logic       mBypass, mPend, mValid = 1'b0;

  eq_coef_regbank dut (
    .clk_i(clk), .rst_ni(rstN),
    .reg_addr_i(regAddr), .reg_data_i(regData), .reg_we_i(regWe),
    .rd_addr_i(rdAddr), .rd_data_o(rdData),
    .sample_tick_i(sampleTick), .gain_flat_o(gainFlat),
    .bypass_o(bypass), .commit_pending_o(commitPending), .ramping_o(ramping)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic modelRamping();
    logic r = 1'b0;
    if (RampEn)
      for (int i = 0; i < NB; i++) if (mActive[i] != mTarget[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] modelRead(input logic [7:0] a);
    int off = int'(a) - int'(BandBase);
    if (off >= 0 && off < NB) return mShadow[off];
    if (a == CtrlA) return {6'b0, mBypass, 1'b0};
    if (a == StatA) return {6'b0, modelRamping(), mPend};
    if (a == StepA) return mStep;
    return 8'h00;
  endfunction

  // One model step from the current inputs and the pre-edge model state.
  task automatic modelStep();
    logic [7:0] newRd;
    int t, a, d, s;
    if (!rstN) begin
      for (int i = 0; i < NB; i++) begin
        mShadow[i] = 8'h00; mTarget[i] = 8'h00; mActive[i] = 8'h00;
      end
      mStep = 8'd1; mBypass = 1'b0; mPend = 1'b0; mRd = 8'h00; mValid = 1'b1;
    end else if (mValid) begin
      newRd = modelRead(rdAddr);
      if (sampleTick) begin
        for (int i = 0; i < NB; i++) begin
          if (RampEn) begin
            t = $signed(mTarget[i]); a = $signed(mActive[i]); d = t - a;
            s = int'(mStep);
            if (s == 0 || (d < 0 ? -d : d) <= s) a = t;
            else a = (d > 0) ? a + s : a - s;
            mActive[i] = 8'(a);
            if (mPend) mTarget[i] = mShadow[i];
          end else if (mPend) begin
            mActive[i] = mShadow[i];
          end
        end
        mPend = 1'b0;
      end
      if (regWe) begin
        if (int'(regAddr) - int'(BandBase) >= 0 && int'(regAddr) - int'(BandBase) < NB)
          mShadow[int'(regAddr) - int'(BandBase)] = regData;
        else if (regAddr == CtrlA) begin
          if (regData[0]) mPend = 1'b1;
          mBypass = regData[1];
        end else if (regAddr == StepA) mStep = regData;
      end
      mRd = newRd;
    end
  endtask

  task automatic compareAll();
    logic [NB*8-1:0] expGain;
    if (!mValid) return;
    for (int i = 0; i < NB; i++) expGain[8*i +: 8] = mActive[i];
    checkOutput("gain_flat", 64'(gainFlat), 64'(expGain));
    checkOutput("rd_data", 64'(rdData), 64'(mRd));
    checkOutput("bypass", 64'(bypass), 64'(mBypass));
    checkOutput("commit_pending", 64'(commitPending), 64'(mPend));
    checkOutput("ramping", 64'(ramping), 64'(modelRamping()));
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic applyStimulus(input logic rn, input logic we,
                               input logic [7:0] addr, input logic [7:0] data,
                               input logic [7:0] rd, input logic tick);
    rstN = rn; regWe = we; regAddr = addr; regData = data;
    rdAddr = rd; sampleTick = tick;
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, 1'b1, addr, data, StatA, 1'b0);
  endtask

  task automatic tick(input logic [7:0] rd);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, rd, 1'b1);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, StatA, 1'b0);
  endtask

  function automatic logic [7:0] band(input int i);
    return gainFlat[8*i +: 8];
  endfunction

  function automatic logic [7:0] pickAddr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return BandBase + 8'($urandom_range(0, NB - 1));
      4: return BandBase + 8'($urandom_range(NB, NB + 7));
      5, 6: return CtrlA;
      7: return StatA;
      8: return StepA;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Directed sequences with hand-computed values, then randomized traffic.
  initial begin
    logic [7:0] a, d;
    rstN = 1'b0; regWe = 1'b0; regAddr = 8'h00; regData = 8'h00;
    rdAddr = StepA; sampleTick = 1'b0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, StepA, 1'b0);
    checkOutput("reset_gain", 64'(gainFlat), 64'h0);
    checkOutput("reset_rd", 64'(rdData), 64'h00);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, StepA, 1'b0);
    checkOutput("reset_step_read", 64'(rdData), 64'h01);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, StatA, 1'b0);
    checkOutput("reset_status", 64'(rdData), 64'h00);

    // Uncommitted shadow write leaves the active gain alone
    wr(8'h02, 8'h10);
    for (int i = 0; i < 5; i++) tick(8'h02);
    checkOutput("nocommit_band2", 64'(band(2)), 64'h00);
    checkOutput("nocommit_read", 64'(rdData), 64'h10);

    // Commit with step 4, band0 ramps 0 -> 4 -> 8 -> 10
    doReset();
    wr(StepA, 8'h04); wr(8'h00, 8'h0A); wr(CtrlA, 8'h01);
    checkOutput("commit_set", 64'(commitPending), 64'h1);
    tick(StatA);
    checkOutput("commit_clear", 64'(commitPending), 64'h0);
    checkOutput("ramp_t1", 64'(band(0)), RampEn ? 64'h00 : 64'h0A);
    tick(StatA);
    checkOutput("ramp_t2", 64'(band(0)), RampEn ? 64'h04 : 64'h0A);
    tick(StatA);
    checkOutput("ramp_t3", 64'(band(0)), RampEn ? 64'h08 : 64'h0A);
    checkOutput("ramping_mid", 64'(ramping), RampEn ? 64'h1 : 64'h0);
    tick(StatA);
    checkOutput("ramp_t4", 64'(band(0)), 64'h0A);
    checkOutput("ramping_done", 64'(ramping), 64'h0);

    // Full-scale jump 127 -> -128 with a large step, no wrap
    doReset();
    wr(StepA, 8'hFF); wr(8'h01, 8'h7F); wr(CtrlA, 8'h01);
    tick(StatA); tick(StatA);
    checkOutput("jump_pre", 64'(band(1)), 64'h7F);
    wr(8'h01, 8'h80); wr(CtrlA, 8'h01);
    tick(StatA); tick(StatA);
    checkOutput("jump_post", 64'(band(1)), 64'h80);

    // Commit write coinciding with the committing tick re-arms the request
    doReset();
    wr(8'h03, 8'h05); wr(CtrlA, 8'h01);
    applyStimulus(1'b1, 1'b1, CtrlA, 8'h01, StatA, 1'b1);
    checkOutput("rearm_pending", 64'(commitPending), 64'h1);
    checkOutput("rearm_band3", 64'(band(3)), RampEn ? 64'h00 : 64'h05);
    applyStimulus(1'b1, 1'b1, 8'h03, 8'h09, StatA, 1'b1);
    checkOutput("second_commit", 64'(commitPending), 64'h0);
    checkOutput("second_band3", 64'(band(3)), RampEn ? 64'h01 : 64'h05);

    // Reset in the middle of a ramp with a commit pending
    doReset();
    wr(8'h00, 8'h7F); wr(CtrlA, 8'h03);
    tick(StatA); tick(StatA); tick(StatA);
    checkOutput("midramp_band0", 64'(band(0)), RampEn ? 64'h02 : 64'h7F);
    checkOutput("bypass_set", 64'(bypass), 64'h1);
    wr(CtrlA, 8'h01);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, StepA, 1'b0);
    checkOutput("rst_gain", 64'(gainFlat), 64'h0);
    checkOutput("rst_pending", 64'(commitPending), 64'h0);
    checkOutput("rst_bypass", 64'(bypass), 64'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, StepA, 1'b0);
    checkOutput("rst_step", 64'(rdData), 64'h01);

    // Randomized traffic, checked every cycle against the model
    for (int n = 0; n < 4000; n++) begin
      a = pickAddr();
      d = 8'($urandom_range(0, 255));
      if (a == StepA && $urandom_range(0, 3) != 0) d = 8'($urandom_range(0, 6));
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 3),
                    a, d, pickAddr(), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
